// File: rtl/exception_source_unit_if.sv
// Per-source exception bundle: unit request side plus the
// exc_* / ack / discard_done handshake with global control.
interface exception_source_unit_if #(
  parameter int ID_W   = 3,
  parameter int CODE_W = 5
);
  logic              req_valid;
  logic [CODE_W-1:0] req_code;
  logic [ID_W-1:0]   req_id;
  logic [31:0]       req_tval;
  logic              req_ready;
  logic              exc_valid;
  logic [CODE_W-1:0] exc_code;
  logic [ID_W-1:0]   exc_id;
  logic [31:0]       exc_tval;
  logic              exc_ack;
  logic              discard_done;

  modport master (
    output req_valid, req_code, req_id, req_tval,
    output exc_ack, discard_done,
    input  req_ready,
    input  exc_valid, exc_code, exc_id, exc_tval
  );

  modport slave (
    input  req_valid, req_code, req_id, req_tval,
    input  exc_ack, discard_done,
    output req_ready,
    output exc_valid, exc_code, exc_id, exc_tval
  );
endinterface

// File: rtl/exception_source_unit.sv
// Exception source: in-order FIFO of unit exceptions toward global control.
// EXC_SOURCE_TVAL_EN: store/present tval per entry (else exc_tval = 0).
module exception_source_unit #(
  parameter int DEPTH  = 2,
  parameter int ID_W   = 3,
  parameter int CODE_W = 5
) (
  input  logic clk,
  input  logic rst,
  exception_source_unit_if.slave bus,
  output logic overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PENDING = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              exc_valid_q, exc_valid_d;
  logic [CODE_W-1:0] exc_code_q, exc_code_d;
  logic [ID_W-1:0]   exc_id_q, exc_id_d;

  logic [CODE_W-1:0] code_mem [DEPTH];
  logic [ID_W-1:0]   id_mem   [DEPTH];

  logic full;
  logic ready;
  logic ack_hit;
  logic push;

`ifdef EXC_SOURCE_TVAL_EN
  logic [31:0] tval_mem [DEPTH];
  logic [31:0] exc_tval_q, exc_tval_d;
`else
  logic unused_tval;
  assign unused_tval = ^bus.req_tval;
`endif

  assign full    = (count_q == CW'(DEPTH));
  assign ready   = (state_q != DISCARD) && !full;
  // An ack only counts while an exception is actually presented.
  assign ack_hit = (state_q == PENDING) && bus.exc_ack;
  // A push racing the ack belongs to the flushed window: drop it.
  assign push    = bus.req_valid && ready && !ack_hit;

  // Next-state, pointer, occupancy and sticky overflow logic.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (bus.req_valid & ~ready);
    unique case (state_q)
      EMPTY: begin
        if (push) state_d = PENDING;
      end
      PENDING: begin
        if (bus.exc_ack) state_d = DISCARD;
      end
      DISCARD: begin
        if (bus.discard_done) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      count_d  = count_q + CW'(1);
    end
    if (ack_hit) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end
  end

  // Registered exc_* view: head entry while PENDING, zero otherwise.
  always_comb begin
    exc_valid_d = (state_d == PENDING);
    exc_code_d  = '0;
    exc_id_d    = '0;
`ifdef EXC_SOURCE_TVAL_EN
    exc_tval_d  = '0;
`endif
    if (state_d == PENDING) begin
      if (state_q == EMPTY) begin
        exc_code_d = bus.req_code;
        exc_id_d   = bus.req_id;
`ifdef EXC_SOURCE_TVAL_EN
        exc_tval_d = bus.req_tval;
`endif
      end else begin
        exc_code_d = code_mem[rd_ptr_q];
        exc_id_d   = id_mem[rd_ptr_q];
`ifdef EXC_SOURCE_TVAL_EN
        exc_tval_d = tval_mem[rd_ptr_q];
`endif
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      exc_valid_q <= 1'b0;
      exc_code_q  <= '0;
      exc_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      exc_valid_q <= exc_valid_d;
      exc_code_q  <= exc_code_d;
      exc_id_q    <= exc_id_d;
    end
  end

  // Entry storage; appends only, never touches the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        code_mem[i] <= '0;
        id_mem[i]   <= '0;
      end
    end else if (push) begin
      code_mem[wr_ptr_q] <= bus.req_code;
      id_mem[wr_ptr_q]   <= bus.req_id;
    end
  end

`ifdef EXC_SOURCE_TVAL_EN
  // Per-entry trap value storage and its presented copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tval_mem[i] <= '0;
      exc_tval_q <= '0;
    end else begin
      if (push) tval_mem[wr_ptr_q] <= bus.req_tval;
      exc_tval_q <= exc_tval_d;
    end
  end
  assign bus.exc_tval = exc_tval_q;
`else
  assign bus.exc_tval = '0;
`endif

  assign bus.req_ready = ready;
  assign bus.exc_valid = exc_valid_q;
  assign bus.exc_code  = exc_code_q;
  assign bus.exc_id    = exc_id_q;
  assign overflow      = ovf_q;

endmodule

// File: doc/exception_source_unit.md
Name: exception_source_unit

Overview:
- Unit-side producer of the per-source exception interface consumed by global control.
- Sits inside an execution unit (e.g. load/store, branch, CSR) and accepts exception requests from that unit's pipeline.
- Buffers requests in arrival (program) order and presents the oldest as valid/code/id/tval until global control acks it.
- After an ack, drops everything buffered and in flight until global control reports that post-issue discard is complete.

Parameters:
- DEPTH, 2, buffered exception entries; power of two, >=2
- ID_W, 3, instruction id width (LOG2_MAX_IDS)
- CODE_W, 5, exception code width (exception_code_t)

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  unit raises an exception this cycle
- req_code  in  CODE_W  exception code
- req_id  in  ID_W  id of faulting instruction
- req_tval  in  32  trap value
- req_ready  out  1  entry can be accepted this cycle
- exc_valid  out  1  exception pending toward global control
- exc_code  out  CODE_W  code of oldest entry
- exc_id  out  ID_W  id of oldest entry
- exc_tval  out  32  tval of oldest entry
- exc_ack  in  1  global control has taken the presented exception
- discard_done  in  1  one-cycle pulse: global control has finished post-issue discard (store-queue flush point)
- overflow  out  1  sticky: request seen while full or in DISCARD

Behaviour:
- Storage and ordering
  - Circular FIFO of DEPTH entries with {code, id, tval}.
  - Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy count is log2(DEPTH)+1 bits.
  - Requests arrive in program order; the unit guarantees this, and the block never reorders.
- States: EMPTY, PENDING, DISCARD
  - EMPTY: count==0.
    - req_valid & req_ready -> write entry, go to PENDING next cycle.
    - Request-to-exc_valid latency is 1 cycle.
  - PENDING: exc_valid=1; exc_* driven from the head entry, registered.
    - Push allowed while count<DEPTH.
    - exc_ack -> flush the whole FIFO (count<=0, rd_ptr<=wr_ptr), go to DISCARD.
    - Any push in the ack cycle is dropped.
  - DISCARD: exc_valid=0, req_ready=0; incoming requests are dropped.
    - discard_done -> EMPTY.
- Output rules
  - req_ready = (state!=DISCARD) & (count<DEPTH).
  - exc_ack while exc_valid=0 is ignored, and no state change occurs.
  - exc_* hold stable while exc_valid=1 and no ack has occurred.
  - Head does not change while PENDING: pushes only append.
- Boundary cases
  - Full: req_valid with req_ready=0 is not stored and sets overflow.
  - Simultaneous ack and discard_done: ack takes effect, go to DISCARD; that discard_done is ignored.
  - discard_done in EMPTY or PENDING: ignored.
  - Wrap-around: after pointers wrap, ordering and the head entry are preserved.
- Reset, asynchronous, effective immediately, including mid-operation:
  - state=EMPTY, count=0, pointers=0, overflow=0.
  - exc_valid=0, exc_code=0, exc_id=0, exc_tval=0, req_ready=1 after reset deasserts.
- overflow clears only on rst.

Optional Feature:
- Macro: EXC_SOURCE_TVAL_EN
- Defined: tval is stored per entry and presented on exc_tval.
- Undefined: no tval storage; exc_tval is tied to 0 and req_tval is unused. Every other behaviour is identical.

Test Plan:
- Reset then single request (code=5'd4, id=3'd2, tval=32'h1000_0003) -> exc_valid=1 next cycle with those values; hold 5 cycles without ack -> outputs unchanged; ack -> exc_valid=0 next cycle and state DISCARD; discard_done -> req_ready=1.
- DEPTH=2: push ids 1 and 2 back to back -> req_ready=0 after the second; third request (id 3) -> dropped and overflow=1; ack -> both entries cleared, no re-presentation of id 2.
- Request and ack in the same cycle while PENDING (head id 5, new id 6) -> id 6 dropped; after discard_done, exc_valid stays 0.
- Ack and discard_done asserted in the same cycle -> state DISCARD; requests dropped until a later discard_done pulse.
- Assert rst asynchronously mid-PENDING with 2 entries -> exc_valid=0 and all outputs 0 without a clock edge; after release, new request id 7 is presented correctly.
- Wrap-around: 6 single-entry cycles of request, ack, discard_done with ids 0..5 -> each is presented with its correct id and tval. With EXC_SOURCE_TVAL_EN undefined, exc_tval=0 throughout.
